// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator operand sequencer: operand field layout and FSM states.
package accum_pkg;

    localparam int unsigned EXP_HI      = 64;
    localparam int unsigned SGN         = 63;
    localparam int unsigned EXP_MSB     = 62;
    localparam int unsigned EXP_LO      = 52;
    localparam int unsigned MANT_HI_MSB = 51;
    localparam int unsigned MANT_HI_LSB = 33;
    localparam int unsigned HOLE        = 32;
    localparam int unsigned MANT_LO_MSB = 31;

    localparam logic [67:0] ZERO_OP = '0;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StFire,
        StWait,
        StCapt,
        StHold
    } state_e;

endpackage

// File: rtl/accum_slot_buf.sv
// B operand storage: NOPS x W slots with a valid mask; slots never written read back as zero.
module accum_slot_buf #(
    parameter int unsigned NOPS  = 108,
    parameter int unsigned W     = 68,
    parameter int unsigned IDX_W = $clog2(NOPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [W-1:0]      wr_data,
    input  logic              clr,
    output logic [NOPS*W-1:0] rd_data
);

    logic [W-1:0]    mem_q [NOPS];
    logic [NOPS-1:0] mask_q;

    // Data storage needs no reset: the mask hides stale or uninitialised contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= '0;
        end else if (clr) begin
            mask_q <= '0;
        end else if (wr_en) begin
            mask_q[wr_idx] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NOPS; k++) begin : g_rd
        assign rd_data[k*W +: W] = mask_q[k] ? mem_q[k] : '0;
    end

endmodule

// File: rtl/accum_feed_seq.sv
// Operand sequencer and result collector for the explicit-accumulate unit: fills A/B,
// fires the accumulator once, waits for the result (with timeout) and hands it to writeback.
module accum_feed_seq
    import accum_pkg::*;
#(
    parameter int unsigned NOPS  = 108,
    parameter int unsigned W     = 68,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned TMO   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [W-1:0]      op_data,
    input  logic              op_is_a,
    input  logic              op_last,
    input  logic [TAG_W-1:0]  op_tag,
    output logic [W-1:0]      acc_A,
    output logic [NOPS*W-1:0] acc_B,
    output logic              acc_din_en,
    input  logic [W-1:0]      acc_res,
    input  logic              acc_res_en,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [W-1:0]      wb_data,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              wb_ovf,
    output logic              wb_err,
    output logic              stray_res
);

    localparam int unsigned CNT_W = $clog2(NOPS + 1);
    localparam int unsigned IDX_W = $clog2(NOPS);
    localparam int unsigned TMO_W = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NOPS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [TMO_W-1:0] tmo_q;

    logic accept;
    logic room;
    logic wr_b;
    logic slot_clr;

    assign accept   = op_valid & op_ready;
    assign room     = count_q < CNT_MAX;
    assign wr_b     = accept & ~op_is_a & room;
    assign slot_clr = (state_q == StHold) & wb_ready;

    accum_slot_buf #(
        .NOPS  (NOPS),
        .W     (W),
        .IDX_W (IDX_W)
    ) u_slot_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_b),
        .wr_idx  (count_q[IDX_W-1:0]),
        .wr_data (op_data),
        .clr     (slot_clr),
        .rd_data (acc_B)
    );

    // acc_A and acc_B only change in IDLE/FILL, so they stay stable from FIRE through CAPT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            tmo_q      <= '0;
            acc_A      <= '0;
            op_ready   <= 1'b0;
            acc_din_en <= 1'b0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_tag     <= '0;
            wb_ovf     <= 1'b0;
            wb_err     <= 1'b0;
            stray_res  <= 1'b0;
        end else begin
            acc_din_en <= 1'b0;
            if (acc_res_en && state_q != StWait) begin
                stray_res <= 1'b1;
            end
            case (state_q)
                StIdle, StFill: begin
                    op_ready <= 1'b1;
                    if (accept) begin
                        if (state_q == StIdle) begin
                            wb_tag <= op_tag;
                        end
                        if (op_is_a) begin
                            acc_A <= op_data;
                        end else if (room) begin
                            count_q <= count_q + 1'b1;
                        end else begin
                            wb_ovf <= 1'b1;
                        end
                        if (op_last) begin
                            state_q    <= StFire;
                            op_ready   <= 1'b0;
                            acc_din_en <= 1'b1;
                        end else begin
                            state_q <= StFill;
                        end
                    end
                end
                StFire: begin
                    tmo_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (acc_res_en) begin
                        state_q <= StCapt;
                    end else if (tmo_q == TMO_LAST) begin
                        wb_err   <= 1'b1;
                        wb_data  <= '0;
                        wb_valid <= 1'b1;
                        state_q  <= StHold;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StCapt: begin
                    // acc_res is only defined here, the cycle after acc_res_en.
                    wb_data  <= acc_res;
                    wb_valid <= 1'b1;
                    state_q  <= StHold;
                end
                StHold: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        op_ready <= 1'b1;
                        count_q  <= '0;
                        acc_A    <= '0;
                        wb_ovf   <= 1'b0;
                        wb_err   <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_feed_seq.sv
// Directed bench for accum_feed_seq with a nominal/mute accumulator stub and a result scoreboard.
module tb_accum_feed_seq;

    localparam int unsigned NOPS  = 108;
    localparam int unsigned W     = 68;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned TMO   = 12;

    localparam logic [W-1:0] A_ONE    = 68'h0_3FF0_0000_0000_0000;
    localparam logic [W-1:0] B_TWO    = 68'h0_4000_0000_0000_0000;
    localparam logic [W-1:0] STUB_VAL = 68'h0_4008_0000_0000_0000;

    typedef struct packed {
        logic [W-1:0]     data;
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic             err;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              op_valid;
    logic              op_ready;
    logic [W-1:0]      op_data;
    logic              op_is_a;
    logic              op_last;
    logic [TAG_W-1:0]  op_tag;
    logic [W-1:0]      acc_A;
    logic [NOPS*W-1:0] acc_B;
    logic              acc_din_en;
    logic [W-1:0]      acc_res;
    logic              acc_res_en;
    logic              wb_valid;
    logic              wb_ready;
    logic [W-1:0]      wb_data;
    logic [TAG_W-1:0]  wb_tag;
    logic              wb_ovf;
    logic              wb_err;
    logic              stray_res;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   stub_mute = 1'b0;
    int   stub_k = -1;

    accum_feed_seq #(
        .NOPS  (NOPS),
        .W     (W),
        .TAG_W (TAG_W),
        .TMO   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_data    (op_data),
        .op_is_a    (op_is_a),
        .op_last    (op_last),
        .op_tag     (op_tag),
        .acc_A      (acc_A),
        .acc_B      (acc_B),
        .acc_din_en (acc_din_en),
        .acc_res    (acc_res),
        .acc_res_en (acc_res_en),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_tag     (wb_tag),
        .wb_ovf     (wb_ovf),
        .wb_err     (wb_err),
        .stray_res  (stray_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nominal accumulator: res_en 7 cycles after din_en, result valid the following cycle.
    always @(negedge clk) begin
        acc_res_en = 1'b0;
        acc_res    = 'z;
        if (acc_din_en && !stub_mute) begin
            stub_k = 0;
        end else if (stub_k >= 0) begin
            stub_k++;
        end
        if (stub_k == 7) acc_res_en = 1'b1;
        if (stub_k == 8) begin
            acc_res = STUB_VAL;
            stub_k  = -1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] bval(input int k);
        return {4'h8, 32'(k * 7 + 1), ~32'(k)};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one operand from a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic is_a, input logic last,
                        input logic [TAG_W-1:0] tag);
        bit done = 1'b0;
        op_valid = 1'b1;
        op_data  = d;
        op_is_a  = is_a;
        op_last  = last;
        op_tag   = tag;
        for (int i = 0; i < 50; i++) begin
            if (op_ready === 1'b1) begin
                done = 1'b1;
                @(posedge clk);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        op_valid = 1'b0;
        if (!done) check("send_accept", W'(done), W'(1));
    endtask

    task automatic check_slots(input string name, input bit ramp, input int nfill);
        logic [W-1:0] exp;
        for (int k = 0; k < NOPS; k++) begin
            exp = (k < nfill) ? (ramp ? bval(k) : B_TWO) : '0;
            check($sformatf("%s_slot%0d", name, k), acc_B[k*W +: W], exp);
        end
    endtask

    // Called at the negedge right after the last operand's accepting edge (i = edges since then).
    task automatic wait_result(input int exp_lat, input string name);
        int               pulses = 0;
        int               lat = -1;
        bit               stable = 1'b1;
        bit               seen = 1'b0;
        logic [W-1:0]     a_snap;
        logic [NOPS*W-1:0] b_snap;
        exp_t             e;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            if (acc_din_en === 1'b1) begin
                pulses++;
                if (!seen) begin
                    seen   = 1'b1;
                    a_snap = acc_A;
                    b_snap = acc_B;
                end
            end else if (seen && (acc_A !== a_snap || acc_B !== b_snap)) begin
                stable = 1'b0;
            end
            if (wb_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, W'(lat), W'(exp_lat));
        check({name, "_din_pulses"}, W'(pulses), W'(1));
        check({name, "_operands_stable"}, W'(stable), W'(1));
        check({name, "_sb_nonempty"}, W'(sb.size() > 0), W'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, "_wb_data"}, wb_data, e.data);
            check({name, "_wb_tag"}, W'(wb_tag), W'(e.tag));
            check({name, "_wb_ovf"}, W'(wb_ovf), W'(e.ovf));
            check({name, "_wb_err"}, W'(wb_err), W'(e.err));
        end
    endtask

    task automatic release_wb(input string name);
        wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wb_ready = 1'b0;
        check({name, "_valid_dropped"}, W'(wb_valid), W'(0));
        check({name, "_ready_back"}, W'(op_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] held;
        bit           ok;

        rst      = 1'b0;
        op_valid = 1'b0;
        op_data  = '0;
        op_is_a  = 1'b0;
        op_last  = 1'b0;
        op_tag   = '0;
        wb_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_op_ready", W'(op_ready), W'(0));
        check("rst_wb_valid", W'(wb_valid), W'(0));
        check("rst_din_en", W'(acc_din_en), W'(0));
        check("rst_stray", W'(stray_res), W'(0));
        check("rst_acc_A", acc_A, '0);
        check("rst_wb_data", wb_data, '0);
        check("rst_slot0", acc_B[0 +: W], '0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", W'(op_ready), W'(1));

        // Basic fire: A = 1.0, B0 = 2.0; tag taken from the first operand only.
        sb.push_back('{data: STUB_VAL, tag: 8'h5A, ovf: 1'b0, err: 1'b0});
        send(A_ONE, 1'b1, 1'b0, 8'h5A);
        send(B_TWO, 1'b0, 1'b1, 8'hFF);
        check("basic_acc_A", acc_A, A_ONE);
        check_slots("basic", 1'b0, 1);
        wait_result(9, "basic");
        release_wb("basic");

        // Full plus overflow: 110 B operands, the last two dropped.
        sb.push_back('{data: STUB_VAL, tag: 8'h21, ovf: 1'b1, err: 1'b0});
        for (int k = 0; k < NOPS + 2; k++) begin
            send(bval(k), 1'b0, k == NOPS + 1, TAG_W'(8'h21 + k));
        end
        check("ovf_acc_A", acc_A, '0);
        check_slots("ovf", 1'b1, NOPS);
        wait_result(9, "ovf");
        release_wb("ovf");

        // Timeout with a mute accumulator, then 20 cycles of writeback backpressure.
        stub_mute = 1'b1;
        sb.push_back('{data: '0, tag: 8'h33, ovf: 1'b0, err: 1'b1});
        send(A_ONE, 1'b1, 1'b0, 8'h33);
        send(B_TWO, 1'b0, 1'b1, 8'h34);
        wait_result(1 + TMO, "tmo");
        held = wb_data;
        ok   = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (wb_valid !== 1'b1 || wb_data !== held || op_ready !== 1'b0 || wb_err !== 1'b1)
                ok = 1'b0;
        end
        check("backpressure_hold", W'(ok), W'(1));
        release_wb("bp");
        stub_mute = 1'b0;
        check("no_stray_yet", W'(stray_res), W'(0));

        // Reset two cycles after din_en; the late res_en must only raise stray_res.
        send(B_TWO, 1'b0, 1'b1, 8'h44);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ok  = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (wb_valid !== 1'b0) ok = 1'b0;
        end
        check("midreset_no_valid", W'(ok), W'(1));
        check("midreset_stray", W'(stray_res), W'(1));
        check("midreset_wb_data", wb_data, '0);

        // Single-operand group (A only, last) after the reset.
        sb.push_back('{data: STUB_VAL, tag: 8'h77, ovf: 1'b0, err: 1'b0});
        send(A_ONE, 1'b1, 1'b1, 8'h77);
        check("single_acc_A", acc_A, A_ONE);
        check_slots("single", 1'b0, 0);
        wait_result(9, "single");
        release_wb("single");
        check("stray_sticky", W'(stray_res), W'(1));
        check("sb_drained", W'(sb.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
